gcd_datapath: RTL

- Operand/datapath stage that pairs with the GCD controller FSM. Accepts operand pairs over a valid/ready handshake and holds the A/B working registers.
- Produces the `equal` and `a_gt_b` status flags for the controller, and applies the subtract steps the controller commands.
- Sequences each job by holding the controller in reset between jobs. Returns the GCD, the step count and an error/zero flag over a second valid/ready handshake.

---
 rtl/gcd_datapath_if.sv | 36 +++
 rtl/gcd_datapath.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_datapath_if.sv
// ---------------------------------------------------------------------------
// gcd_datapath_if
// Purpose : operand and result handshake bundle of the GCD datapath.
// Signals :
//   in_valid  / in_ready        operand pair handshake (master drives valid)
//   in_a, in_b                  operands, W bits each
//   res_valid / res_ready       result handshake (slave drives valid)
//   res_gcd, res_steps          GCD value and number of subtract steps
//   res_zero                    job had a zero operand and was bypassed
//   res_err                     job was aborted on the busy-cycle limit
// Modports: master = job producer / result consumer, slave = datapath.
// ---------------------------------------------------------------------------
interface gcd_datapath_if #(
   parameter int W = 8
) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_gcd;
   logic [W-1:0] res_steps;
   logic         res_zero;
   logic         res_err;

   modport master (
      output in_valid, in_a, in_b, res_ready,
      input  in_ready, res_valid, res_gcd, res_steps, res_zero, res_err
   );

   modport slave (
      input  in_valid, in_a, in_b, res_ready,
      output in_ready, res_valid, res_gcd, res_steps, res_zero, res_err
   );
endinterface

// File: rtl/gcd_datapath.sv
// ---------------------------------------------------------------------------
// gcd_datapath
// Purpose : operand/datapath stage paired with the GCD controller FSM.
//           Accepts an operand pair, holds the A/B working registers, reports
//           equal / a_gt_b to the controller, applies the subtract steps it
//           commands and returns GCD, step count and zero/error flags.
//           The controller is held in reset (o_core_rst=1) between jobs.
// Ports   :
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   bus             gcd_datapath_if.slave: operand and result handshakes
//   o_core_rst      controller reset, high = controller in its start state
//   i_ctl_load      controller start/load pulse, reloads A/B from operands
//   i_ctl_step      controller is in a subtract state
//   i_ctl_sub       step direction, 1: A<=A-B, 0: B<=B-A
//   i_ctl_found     controller reports equality
//   o_equal         A==B, combinational from the working registers
//   o_a_gt_b        A>B, combinational from the working registers
// Parameters: W operand/result width, MAX_CYC busy-cycle abort limit.
// ---------------------------------------------------------------------------
module gcd_datapath #(
   parameter int W       = 8,
   parameter int MAX_CYC = 1024
) (
   input  logic          clk,
   input  logic          rst,
   gcd_datapath_if.slave bus,
   output logic          o_core_rst,
   input  logic          i_ctl_load,
   input  logic          i_ctl_step,
   input  logic          i_ctl_sub,
   input  logic          i_ctl_found,
   output logic          o_equal,
   output logic          o_a_gt_b
);

   localparam int            BW         = $clog2(MAX_CYC + 1);
   localparam logic [BW-1:0] BUSY_LIMIT = BW'(MAX_CYC);
   localparam logic [BW-1:0] BUSY_ONE   = {{(BW-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]  STEP_ONE   = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]  STEP_MAX   = {W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_op_a;
   logic [W-1:0]  r_op_b;
   logic [W-1:0]  r_steps;
   logic [BW-1:0] r_busy;
   logic          r_in_ready;
   logic          r_res_valid;
   logic [W-1:0]  r_res_gcd;
   logic [W-1:0]  r_res_steps;
   logic          r_res_zero;
   logic          r_res_err;
   logic          r_core_rst;

   logic          w_take;
   logic          w_in_zero;
   logic          w_equal;
   logic          w_a_gt_b;
   logic          w_b_gt_a;
   logic          w_step_a;
   logic          w_step_b;
   logic          w_found;
   logic          w_timeout;
   logic [BW-1:0] w_busy_nxt;
   logic [W-1:0]  w_steps_nxt;

   assign w_take    = bus.in_valid && r_in_ready;
   assign w_in_zero = (bus.in_a == {W{1'b0}}) || (bus.in_b == {W{1'b0}});
   assign w_equal   = (r_a == r_b);
   assign w_a_gt_b  = (r_a > r_b);
   assign w_b_gt_a  = (r_b > r_a);

   // A step is legal only in the direction that cannot underflow; a load
   // in the same cycle takes priority over any step.
   assign w_step_a  = !i_ctl_load && i_ctl_step &&  i_ctl_sub && w_a_gt_b;
   assign w_step_b  = !i_ctl_load && i_ctl_step && !i_ctl_sub && w_b_gt_a;
   assign w_found   = i_ctl_found && w_equal;

   // w_busy_nxt is the number of BUSY cycles including the current one.
   assign w_busy_nxt = r_busy + BUSY_ONE;
   assign w_timeout  = (w_busy_nxt >= BUSY_LIMIT);

   // Saturating step counter next value.
   always_comb begin
      w_steps_nxt = r_steps;
      if ((w_step_a || w_step_b) && (r_steps != STEP_MAX)) begin
         w_steps_nxt = r_steps + STEP_ONE;
      end else begin
         w_steps_nxt = r_steps;
      end
   end

   // Job sequencer, working registers and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_a         <= {W{1'b0}};
         r_b         <= {W{1'b0}};
         r_op_a      <= {W{1'b0}};
         r_op_b      <= {W{1'b0}};
         r_steps     <= {W{1'b0}};
         r_busy      <= {BW{1'b0}};
         r_in_ready  <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_gcd   <= {W{1'b0}};
         r_res_steps <= {W{1'b0}};
         r_res_zero  <= 1'b0;
         r_res_err   <= 1'b0;
         r_core_rst  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_in_ready <= 1'b0;
                  if (w_in_zero) begin
                     // Zero operand: answer directly, controller stays in reset.
                     r_state     <= ST_DONE;
                     r_res_valid <= 1'b1;
                     r_res_gcd   <= bus.in_a | bus.in_b;
                     r_res_steps <= {W{1'b0}};
                     r_res_zero  <= 1'b1;
                     r_res_err   <= 1'b0;
                  end else begin
                     r_state    <= ST_BUSY;
                     r_op_a     <= bus.in_a;
                     r_op_b     <= bus.in_b;
                     r_a        <= bus.in_a;
                     r_b        <= bus.in_b;
                     r_steps    <= {W{1'b0}};
                     r_busy     <= {BW{1'b0}};
                     r_core_rst <= 1'b0;
                  end
               end else begin
                  // Also raises in_ready one cycle after reset release.
                  r_in_ready <= 1'b1;
               end
            end
            ST_BUSY: begin
               r_busy  <= w_busy_nxt;
               r_steps <= w_steps_nxt;
               if (i_ctl_load) begin
                  r_a <= r_op_a;
                  r_b <= r_op_b;
               end else if (w_step_a) begin
                  r_a <= r_a - r_b;
               end else if (w_step_b) begin
                  r_b <= r_b - r_a;
               end else begin
                  r_a <= r_a;
                  r_b <= r_b;
               end
               // Found is checked first so it wins over a simultaneous timeout.
               if (w_found) begin
                  r_state     <= ST_DONE;
                  r_res_valid <= 1'b1;
                  r_res_gcd   <= r_a;
                  r_res_steps <= w_steps_nxt;
                  r_res_zero  <= 1'b0;
                  r_res_err   <= 1'b0;
                  r_core_rst  <= 1'b1;
               end else if (w_timeout) begin
                  r_state     <= ST_DONE;
                  r_res_valid <= 1'b1;
                  r_res_gcd   <= {W{1'b0}};
                  r_res_steps <= w_steps_nxt;
                  r_res_zero  <= 1'b0;
                  r_res_err   <= 1'b1;
                  r_core_rst  <= 1'b1;
               end else begin
                  r_state <= ST_BUSY;
               end
            end
            ST_DONE: begin
               if (r_res_valid && bus.res_ready) begin
                  r_state     <= ST_IDLE;
                  r_res_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_res_valid <= 1'b0;
               r_in_ready  <= 1'b0;
               r_core_rst  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.res_valid = r_res_valid;
   assign bus.res_gcd   = r_res_gcd;
   assign bus.res_steps = r_res_steps;
   assign bus.res_zero  = r_res_zero;
   assign bus.res_err   = r_res_err;
   assign o_core_rst    = r_core_rst;
   assign o_equal       = w_equal;
   assign o_a_gt_b      = w_a_gt_b;

endmodule
